// File: rtl/fir_pkg.sv
// ----------------------------------------------------------------------------
// fir_pkg
// Shared definitions for the FIR processing chain.
//   FIR_DATA_W    : sample width produced by the 21-tap symmetric FIR
//   ST_*          : status-bit encoding shared by the FIR-chain stages
//   fir_status_t  : packed view of the same status bits
//   clog2()       : elaboration-time ceiling log2 helper
// ----------------------------------------------------------------------------
package fir_pkg;

    localparam int FIR_DATA_W   = 12;

    // Status-bit positions used by every stage that reports status upstream.
    localparam int ST_VALID_BIT = 0;
    localparam int ST_OVF_BIT   = 1;
    localparam int ST_W         = 2;

    typedef struct packed {
        logic ovf;
        logic valid;
    } fir_status_t;

    // Ceiling log2; returns 0 for values of 0 or 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < value) begin
                r = i + 1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fir_decim_fifo_sync_fifo.sv
// ----------------------------------------------------------------------------
// sync_fifo
// First-word fall-through synchronous FIFO with explicit level tracking.
// A push into a full FIFO is dropped (drop_o pulses) unless a pop happens in
// the same cycle. Memory contents are not reset.
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-low reset
//   push_i   in   write wdata_i this cycle
//   wdata_i  in   DATA_W write data
//   pop_i    in   consumer takes the head (ignored while empty)
//   rdata_o  out  head entry, 0 while empty
//   valid_o  out  FIFO not empty
//   level_o  out  occupancy 0..DEPTH
//   drop_o   out  push was discarded because the FIFO was full
// ----------------------------------------------------------------------------
module sync_fifo
    import fir_pkg::*;
#(
    parameter int  DATA_W = FIR_DATA_W,
    parameter int  DEPTH  = 8,
    localparam int AW     = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              valid_o,
    output logic [AW:0]       level_o,
    output logic              drop_o
);

    localparam logic [AW:0] LEVEL_FULL = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       level_q, level_d;
    logic              empty_s, full_s, pop_s, push_s;

    // Qualify push/pop against occupancy and compute next pointers/level.
    always_comb begin
        empty_s = (level_q == {(AW+1){1'b0}});
        full_s  = (level_q == LEVEL_FULL);
        pop_s   = pop_i && !empty_s;
        // A pop in the same cycle frees a slot, so a full FIFO still accepts.
        push_s  = push_i && (!full_s || pop_s);
        drop_o  = push_i && full_s && !pop_s;

        wr_ptr_d = push_s ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
        rd_ptr_d = pop_s  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;

        case ({push_s, pop_s})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase
    end

    // Pointer and level state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            level_q  <= {(AW+1){1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array; intentionally not reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Fall-through head; forced to zero while empty so stale data never leaks.
    always_comb begin
        valid_o = !empty_s;
        level_o = level_q;
        rdata_o = empty_s ? {DATA_W{1'b0}} : mem_q[rd_ptr_q];
    end

endmodule

// File: rtl/fir_decim_fifo.sv
// ----------------------------------------------------------------------------
// fir_decim_fifo
// Decimating buffer stage downstream of the 21-tap symmetric FIR. Keeps one
// sample out of every DECIM valid input samples, buffers kept samples in a
// FWFT FIFO and presents them on a valid/ready interface. A sticky overflow
// flag records kept samples lost to a full FIFO.
//
// Build option: macro FIR_DECIM_AVG_EN
//   undefined : pick mode, the last sample of each DECIM group is kept
//   defined   : average mode, the rounded mean of each DECIM group is kept
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-low reset
//   in_data    in   DATA_W signed FIR output sample
//   in_valid   in   in_data carries a new sample
//   out_data   out  FIFO head, 0 while out_valid=0
//   out_valid  out  FIFO not empty
//   out_ready  in   sink accepts the head when out_valid=1
//   level      out  FIFO occupancy 0..FIFO_DEPTH
//   overflow   out  sticky lost-sample flag
//   clr_ovf    in   synchronous clear of overflow (an overflow event wins)
// ----------------------------------------------------------------------------
module fir_decim_fifo
    import fir_pkg::*;
#(
    parameter int  DATA_W     = FIR_DATA_W,
    parameter int  DECIM      = 4,
    parameter int  FIFO_DEPTH = 8,
    localparam int AW         = clog2(FIFO_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [AW:0]       level,
    output logic              overflow,
    input  logic              clr_ovf
);

    // S is the shift that turns a DECIM-sample sum into a mean.
    localparam int            S    = clog2(DECIM);
    localparam int            PW   = (S > 0) ? S : 1;
    localparam logic [PW-1:0] LAST = PW'(DECIM - 1);

    logic [PW-1:0]     phase_q, phase_d;
    logic              last_s;
    logic              push_s;
    logic [DATA_W-1:0] push_data_s;
    logic              drop_s;
    logic              ovf_q, ovf_d;

    // Phase counter advances only on valid samples; the group closes at LAST.
    always_comb begin
        last_s = (phase_q == LAST);
        push_s = in_valid && last_s;
        if (in_valid) begin
            phase_d = last_s ? {PW{1'b0}} : (phase_q + PW'(1));
        end else begin
            phase_d = phase_q;
        end
    end

    // Phase register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q <= {PW{1'b0}};
        end else begin
            phase_q <= phase_d;
        end
    end

`ifdef FIR_DECIM_AVG_EN
    // Accumulator holds the partial sum of up to DECIM-1 samples.
    localparam int                SW  = DATA_W + S + 1;
    localparam logic [SW-1:0]     RND = SW'((2 ** S) / 2);

    logic [DATA_W+S-1:0] acc_q, acc_d;
    logic [SW-1:0]       sum_s, rsum_s, shf_s;
    logic                unused_shf_s;

    // Sign-extended running sum, half-up rounding and arithmetic shift.
    always_comb begin
        sum_s  = {acc_q[DATA_W+S-1], acc_q}
               + {{(S+1){in_data[DATA_W-1]}}, in_data};
        rsum_s = sum_s + RND;
        shf_s  = SW'($signed(rsum_s) >>> S);
        // The mean of DECIM in-range samples always fits DATA_W.
        push_data_s  = shf_s[DATA_W-1:0];
        unused_shf_s = ^shf_s[SW-1:DATA_W];
        if (in_valid) begin
            acc_d = last_s ? {(DATA_W+S){1'b0}} : sum_s[DATA_W+S-1:0];
        end else begin
            acc_d = acc_q;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= {(DATA_W+S){1'b0}};
        end else begin
            acc_q <= acc_d;
        end
    end
`else
    // Pick mode keeps the sample that closes the group.
    always_comb begin
        push_data_s = in_data;
    end
`endif

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_s),
        .wdata_i (push_data_s),
        .pop_i   (out_ready),
        .rdata_o (out_data),
        .valid_o (out_valid),
        .level_o (level),
        .drop_o  (drop_s)
    );

    // Sticky overflow: a drop in the same cycle as a clear keeps the flag set.
    always_comb begin
        if (drop_s) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Overflow register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign overflow = ovf_q;

endmodule

// File: tb/tb_fir_decim_fifo.sv
module tb_fir_decim_fifo;

    logic        clk;
    logic        rst;
    logic [11:0] in_data;
    logic        in_valid;
    logic [11:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  level;
    logic        overflow;
    logic        clr_ovf;

    int total;
    int bad;

    fir_decim_fifo #(
        .DATA_W     (12),
        .DECIM      (4),
        .FIFO_DEPTH (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid  = 1'b0;
        in_data   = 12'd0;
        out_ready = 1'b0;
        clr_ovf   = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_data   = 12'($urandom);
            in_valid  = 1'($urandom);
            out_ready = 1'($urandom);
            clr_ovf   = 1'($urandom);
            tick();
            total++;
            if (out_valid !== 1'b0 || out_data !== 12'd0 || level !== 4'd0 || overflow !== 1'b0) begin
                bad++;
                $display("FAIL reset_hold: valid=%b data=%0d level=%0d ovf=%b, required 0/0/0/0",
                         out_valid, out_data, level, overflow);
            end
        end
        idle_inputs();
        rst = 1'b1;
        // Constant group value: same result in pick and average modes.
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1;
            in_data  = 12'd7;
            tick();
            total++;
            if (level !== ((i == 4) ? 4'd1 : 4'd0) || out_data !== ((i == 4) ? 12'd7 : 12'd0)) begin
                bad++;
                $display("FAIL first_push s%0d: level=%0d data=%0d, required %0d/%0d",
                         i, level, out_data, (i == 4) ? 1 : 0, (i == 4) ? 7 : 0);
            end
        end
        // Asynchronous reset asserted mid-cycle, checked before any clock edge.
        idle_inputs();
        in_valid = 1'b1;
        in_data  = 12'd9;
        tick();
        in_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || level !== 4'd0 || out_data !== 12'd0) begin
            bad++;
            $display("FAIL async_flush: valid=%b level=%0d data=%0d, required 0/0/0",
                     out_valid, level, out_data);
        end
        tick();
        rst = 1'b1;
        // Phase restarted: push again on the 4th valid sample after release.
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1;
            in_data  = 12'd9;
            tick();
            total++;
            if (level !== ((i == 4) ? 4'd1 : 4'd0)) begin
                bad++;
                $display("FAIL phase_after_reset s%0d: level=%0d, required %0d",
                         i, level, (i == 4) ? 1 : 0);
            end
        end
        total++;
        if (out_data !== 12'd9) begin
            bad++;
            $display("FAIL phase_after_reset data: got %0d, required 9", out_data);
        end
        apply_reset();
    endtask

    task automatic test_pick();
        out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            in_valid = 1'b1;
            in_data  = 12'(i);
            tick();
            total++;
            if (out_valid !== ((i % 4) == 0) || out_data !== (((i % 4) == 0) ? 12'(i) : 12'd0)) begin
                bad++;
                $display("FAIL pick s%0d: valid=%b data=%0d, required %b/%0d",
                         i, out_valid, out_data, ((i % 4) == 0), ((i % 4) == 0) ? i : 0);
            end
        end
        apply_reset();
    endtask

    task automatic test_gapped();
        int n;
        int exp_level;
        n = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 32; c++) begin
            in_valid = ((c % 2) == 0);
            in_data  = 12'(100 + c);
            if ((c % 2) == 0) n++;
            tick();
            exp_level = n / 4;
            total++;
            if (level !== 4'(exp_level) || out_data !== ((exp_level > 0) ? 12'd106 : 12'd0)) begin
                bad++;
                $display("FAIL gapped c%0d: level=%0d data=%0d, required %0d/%0d",
                         c, level, out_data, exp_level, (exp_level > 0) ? 106 : 0);
            end
        end
        apply_reset();
    endtask

    task automatic test_full();
        out_ready = 1'b0;
        for (int i = 1; i <= 36; i++) begin
            in_valid = 1'b1;
            in_data  = 12'(i);
            tick();
            if (i == 32 || i == 36) begin
                total++;
                if (level !== 4'd8 || overflow !== (i == 36)) begin
                    bad++;
                    $display("FAIL full s%0d: level=%0d ovf=%b, required 8/%b",
                             i, level, overflow, (i == 36));
                end
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            total++;
            if (out_valid !== 1'b1 || out_data !== 12'(4 * (k + 1))) begin
                bad++;
                $display("FAIL full_drain p%0d: valid=%b data=%0d, required 1/%0d",
                         k, out_valid, out_data, 4 * (k + 1));
            end
            tick();
        end
        total++;
        if (level !== 4'd0 || out_valid !== 1'b0 || overflow !== 1'b1) begin
            bad++;
            $display("FAIL full_empty: level=%0d valid=%b ovf=%b, required 0/0/1",
                     level, out_valid, overflow);
        end
        out_ready = 1'b0;
        clr_ovf   = 1'b1;
        tick();
        clr_ovf = 1'b0;
        total++;
        if (overflow !== 1'b0) begin
            bad++;
            $display("FAIL clr_ovf: got %b, required 0", overflow);
        end
        apply_reset();
    endtask

    task automatic test_full_simul();
        out_ready = 1'b0;
        for (int i = 1; i <= 36; i++) begin
            in_valid  = 1'b1;
            in_data   = 12'(i);
            out_ready = (i == 36);
            tick();
        end
        out_ready = 1'b0;
        total++;
        if (level !== 4'd8 || overflow !== 1'b0 || out_data !== 12'd8) begin
            bad++;
            $display("FAIL full_push_pop: level=%0d ovf=%b head=%0d, required 8/0/8",
                     level, overflow, out_data);
        end
        // Drop coinciding with a clear: the set must win.
        for (int i = 37; i <= 40; i++) begin
            in_valid = 1'b1;
            in_data  = 12'(i);
            clr_ovf  = (i == 40);
            tick();
        end
        clr_ovf = 1'b0;
        total++;
        if (overflow !== 1'b1 || level !== 4'd8) begin
            bad++;
            $display("FAIL set_wins: ovf=%b level=%0d, required 1/8", overflow, level);
        end
        in_valid = 1'b0;
        clr_ovf  = 1'b1;
        tick();
        clr_ovf = 1'b0;
        total++;
        if (overflow !== 1'b0) begin
            bad++;
            $display("FAIL clr_after_set: got %b, required 0", overflow);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            total++;
            if (out_data !== 12'(8 + 4 * k)) begin
                bad++;
                $display("FAIL wrap_drain p%0d: got %0d, required %0d", k, out_data, 8 + 4 * k);
            end
            tick();
        end
        tick();
        total++;
        if (level !== 4'd0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL pop_empty: level=%0d valid=%b, required 0/0", level, out_valid);
        end
        apply_reset();
    endtask

`ifdef FIR_DECIM_AVG_EN
    task automatic test_avg();
        int vals [16] = '{1, 2, 3, 4, -2047, -2047, -2047, -2047,
                          2047, 2047, 2047, 2047, -1, -1, -1, -2};
        int expv [4]  = '{3, -2047, 2047, -1};
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_data  = 12'(vals[i]);
            tick();
        end
        in_valid = 1'b0;
        total++;
        if (level !== 4'd4) begin
            bad++;
            $display("FAIL avg_level: got %0d, required 4", level);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            total++;
            if (out_data !== 12'(expv[k])) begin
                bad++;
                $display("FAIL avg g%0d: got %0d, required %0d", k, $signed(out_data), expv[k]);
            end
            tick();
        end
        apply_reset();
    endtask
`endif

    initial begin
        clk   = 1'b0;
        rst   = 1'b0;
        total = 0;
        bad   = 0;
        idle_inputs();
        test_reset();
`ifdef FIR_DECIM_AVG_EN
        test_avg();
`else
        test_pick();
        test_gapped();
        test_full();
        test_full_simul();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
